// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft
// Single-clock FIFO with an occupancy count, programmable almost-full and
// almost-empty flags, sticky overflow/underflow error flags, and a
// selectable read mode (registered read or first-word-fall-through).
//
// Handshake: a write is accepted on a rising clk edge when winc=1 and
// wfull=0; a read/pop is accepted when rinc=1 and rempty=0. A request made
// against a full (write) or empty (read) FIFO is dropped and sets the
// matching sticky error flag. There is no full-FIFO bypass.
//
// Ports:
//   clk           single clock, all logic on the rising edge
//   rst           synchronous active-high reset
//   winc, wdata   write request and data
//   wfull         FIFO holds DEPTH words
//   walmost_full  count >= AF_LEVEL
//   rinc          read request / pop
//   rdata         read data (registered, or head word when FWFT=1)
//   rempty        FIFO holds no words
//   ralmost_empty count <= AE_LEVEL
//   count         occupancy 0..DEPTH
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty
//   clr_err       clears overflow/underflow (a same-cycle new error wins)
module sync_fifo_fwft #(
  parameter int DSIZE    = 8,
  parameter int ASIZE    = 4,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             walmost_full,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] DEPTH_C = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AF_C    = (ASIZE+1)'(AF_LEVEL);
  localparam logic [ASIZE:0] AE_C    = (ASIZE+1)'(AE_LEVEL);
  localparam logic [ASIZE:0] ZERO_C  = '0;

  logic [DSIZE-1:0] mem [DEPTH];

  logic [ASIZE:0] wbin;
  logic [ASIZE:0] rbin;
  logic [ASIZE:0] wbin_next;
  logic [ASIZE:0] rbin_next;
  logic [ASIZE:0] count_next;
  logic           wr_ok;
  logic           rd_ok;

  assign wr_ok = winc & ~wfull;
  assign rd_ok = rinc & ~rempty;

  assign wbin_next = wbin + (ASIZE+1)'(wr_ok);
  assign rbin_next = rbin + (ASIZE+1)'(rd_ok);

  // The pointers carry one extra wrap bit, so their modular difference is
  // exactly count + wr_ok - rd_ok over the full 0..DEPTH range.
  assign count_next = wbin_next - rbin_next;

  // Pointers, occupancy and flags. Flags come from count_next so they line
  // up with the registered count in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbin          <= '0;
      rbin          <= '0;
      count         <= '0;
      wfull         <= 1'b0;
      rempty        <= 1'b1;
      walmost_full  <= 1'b0;
      ralmost_empty <= 1'b1;
    end else begin
      wbin          <= wbin_next;
      rbin          <= rbin_next;
      count         <= count_next;
      wfull         <= (count_next == DEPTH_C);
      rempty        <= (count_next == ZERO_C);
      walmost_full  <= (count_next >= AF_C);
      ralmost_empty <= (count_next <= AE_C);
    end
  end

  // Storage is not reset; writes are suppressed during reset so a request
  // in the reset cycle leaves no trace.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wbin[ASIZE-1:0]] <= wdata;
    end
  end

  // Sticky error flags: a new error in the same cycle as clr_err wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (winc && wfull) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (rinc && rempty) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

  generate
    if (FWFT == 0) begin : g_std_read
      // Registered read: the popped word appears one cycle after the rinc
      // edge and holds until the next accepted read.
      logic [DSIZE-1:0] rdata_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_q <= '0;
        end else if (rd_ok) begin
          rdata_q <= mem[rbin[ASIZE-1:0]];
        end
      end
      assign rdata = rdata_q;
    end else begin : g_fwft_read
      // Head word falls through combinationally; meaningless while empty.
      assign rdata = mem[rbin[ASIZE-1:0]];
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed bench for sync_fifo_fwft with default parameters: one standard
// read-mode instance driven by a step task against a reference model with an
// expected-data queue, and one FWFT instance exercised by a short sequence.
module tb_sync_fifo_fwft;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // standard-read instance
  logic       winc = 1'b0;
  logic [7:0] wdata = '0;
  logic       rinc = 1'b0;
  logic       clr_err = 1'b0;
  logic       wfull, walmost_full, rempty, ralmost_empty, overflow, underflow;
  logic [7:0] rdata;
  logic [4:0] count;

  // FWFT instance
  logic       f_winc = 1'b0;
  logic [7:0] f_wdata = '0;
  logic       f_rinc = 1'b0;
  logic       f_clr_err = 1'b0;
  logic       f_wfull, f_walmost_full, f_rempty, f_ralmost_empty, f_overflow, f_underflow;
  logic [7:0] f_rdata;
  logic [4:0] f_count;

  sync_fifo_fwft #(.DSIZE(8), .ASIZE(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_std (
    .clk(clk), .rst(rst),
    .winc(winc), .wdata(wdata), .wfull(wfull), .walmost_full(walmost_full),
    .rinc(rinc), .rdata(rdata), .rempty(rempty), .ralmost_empty(ralmost_empty),
    .count(count), .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  sync_fifo_fwft #(.DSIZE(8), .ASIZE(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst),
    .winc(f_winc), .wdata(f_wdata), .wfull(f_wfull), .walmost_full(f_walmost_full),
    .rinc(f_rinc), .rdata(f_rdata), .rempty(f_rempty), .ralmost_empty(f_ralmost_empty),
    .count(f_count), .overflow(f_overflow), .underflow(f_underflow), .clr_err(f_clr_err)
  );

  // ---------------- scoreboard / model state ----------------
  int         n_cmp = 0;
  int         n_err = 0;
  int         m_count = 0;
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic [7:0] m_rdata = '0;
  logic [7:0] exp_q[$];
  logic       armed = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("count",         32'(count),         32'(m_count));
    chk("rempty",        32'(rempty),        32'(m_count == 0));
    chk("wfull",         32'(wfull),         32'(m_count == 16));
    chk("walmost_full",  32'(walmost_full),  32'(m_count >= 14));
    chk("ralmost_empty", 32'(ralmost_empty), 32'(m_count <= 2));
    chk("overflow",      32'(overflow),      32'(m_ovf));
    chk("underflow",     32'(underflow),     32'(m_unf));
    chk("rdata",         32'(rdata),         32'(m_rdata));
  endtask

  // ---------------- driver tasks ----------------
  // One clock of stimulus on the standard instance, then model update and check.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    logic wr_ok, rd_ok;
    winc = w; wdata = d; rinc = r; clr_err = c;
    wr_ok = w && (m_count != 16);
    rd_ok = r && (m_count != 0);
    @(posedge clk); #1;
    winc = 1'b0; rinc = 1'b0; clr_err = 1'b0;
    if (w && m_count == 16) m_ovf = 1'b1;
    else if (c)             m_ovf = 1'b0;
    if (r && m_count == 0)  m_unf = 1'b1;
    else if (c)             m_unf = 1'b0;
    if (rd_ok) m_rdata = exp_q.pop_front();
    if (wr_ok) exp_q.push_back(d);
    m_count = m_count + int'(wr_ok) - int'(rd_ok);
    check_state();
  endtask

  // Reset with requests held high; they must be ignored.
  task automatic do_reset();
    rst = 1'b1; winc = 1'b1; rinc = 1'b1; wdata = 8'hEE;
    @(posedge clk); #1;
    rst = 1'b0; winc = 1'b0; rinc = 1'b0;
    m_count = 0; m_ovf = 1'b0; m_unf = 1'b0; m_rdata = '0;
    exp_q.delete();
    check_state();
  endtask

  // Occupancy must stay inside 0..DEPTH on every cycle.
  always @(negedge clk) begin
    if (armed && !rst) begin
      n_cmp++;
      assert (count <= 5'd16 && f_count <= 5'd16) else begin
        n_err++;
        $error("FAIL count_range: observed %0d/%0d expected <= 16", count, f_count);
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    // reset and idle
    do_reset();
    armed = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // fill 0x01..0x10, flags rise at 14 and 16
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    // 17th write dropped, overflow set
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    // drain in order
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // pointer wrap: 6/6 then 16/16
    for (int i = 0; i < 6; i++)  step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)  step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // full with simultaneous write and read: read wins, write dropped
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // empty with simultaneous write and read: write wins, underflow set
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    // clr_err together with a new underflow: set wins
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // non-boundary simultaneous write and read keeps count
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // FWFT instance: first write falls through
    f_winc = 1'b1; f_wdata = 8'h33;
    @(posedge clk); #1;
    f_winc = 1'b0;
    chk("fwft_rempty_after_wr", 32'(f_rempty), 32'(1'b0));
    chk("fwft_rdata_first",     32'(f_rdata),  32'(8'h33));
    f_winc = 1'b1; f_wdata = 8'h44;
    @(posedge clk); #1;
    f_winc = 1'b0;
    chk("fwft_rdata_hold", 32'(f_rdata), 32'(8'h33));
    chk("fwft_count2",     32'(f_count), 32'(2));
    f_rinc = 1'b1;
    @(posedge clk); #1;
    f_rinc = 1'b0;
    chk("fwft_rdata_next", 32'(f_rdata), 32'(8'h44));
    chk("fwft_count1",     32'(f_count), 32'(1));
    f_rinc = 1'b1;
    @(posedge clk); #1;
    f_rinc = 1'b0;
    chk("fwft_rempty_drained", 32'(f_rempty),    32'(1'b1));
    chk("fwft_underflow",      32'(f_underflow), 32'(1'b0));

    // reset mid-operation with 9 stored words
    for (int i = 0; i < 9; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    do_reset();
    step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
